// File: rtl/icosoc_arb_pkg.sv
// Shared definitions for the icosoc FIFO arbiters: state encoding and tag-width helper.
package icosoc_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Channel tag width; a single requester still gets a 1-bit tag.
  function automatic int tagw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/icosoc_rr_pick.sv
// Combinational round-robin pick: first set request bit scanning upward
// cyclically from the entry after the last-served pointer.
module icosoc_rr_pick
  import icosoc_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = tagw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            found,
  output logic [IDW-1:0]  sel
);

  always_comb begin : scan
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/icosoc_fifo_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among NREQ
// requesters; each written word is tagged {channel, payload}.
module icosoc_fifo_arbiter
  import icosoc_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 16,
  localparam int IDW     = tagw(NREQ)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_shift,
  output logic [IDW+WIDTH-1:0]  fifo_data,
  input  logic                  fifo_full,
  output logic                  grant_valid,
  output logic [IDW-1:0]        grant_id
);

  localparam int CNTW = $clog2(MAXBURST) + 1;

  arb_state_t      state;
  logic [IDW-1:0]  ptr;
  logic [CNTW-1:0] cnt;
  logic            found;
  logic [IDW-1:0]  sel;
  logic            burst_end;

  icosoc_rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req  (req_valid),
    .last (ptr),
    .found(found),
    .sel  (sel)
  );

  // Handshake is gated by resetn so nothing is written in a reset cycle.
  always_comb begin
    req_ready  = '0;
    fifo_shift = 1'b0;
    if (resetn && state == BURST) begin
      req_ready[grant_id] = !fifo_full;
      fifo_shift          = req_valid[grant_id] && !fifo_full;
    end
  end

  assign fifo_data = {grant_id, req_data[int'(grant_id)*WIDTH +: WIDTH]};
  assign burst_end = req_last[grant_id] || (cnt == CNTW'(MAXBURST - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= IDW'(NREQ - 1);
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state       <= BURST;
            grant_valid <= 1'b1;
            grant_id    <= sel;
            ptr         <= sel;
            cnt         <= '0;
          end
        end
        BURST: begin
          if (fifo_shift) begin
            cnt <= cnt + CNTW'(1);
            if (burst_end) begin
              state       <= IDLE;
              grant_valid <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icosoc_fifo_arbiter.sv
// Directed cycle-by-cycle vectors for icosoc_fifo_arbiter (NREQ=4, WIDTH=8, MAXBURST=4).
module tb_icosoc_fifo_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_shift;
  logic [9:0]  fifo_data;
  logic        fifo_full;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int errors = 0;
  int checks = 0;

  icosoc_fifo_arbiter #(
    .NREQ    (4),
    .WIDTH   (8),
    .MAXBURST(4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_shift (fifo_shift),
    .fifo_data  (fifo_data),
    .fifo_full  (fifo_full),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic        gv;
    logic [1:0]  gid;
    logic [3:0]  ready;
    logic        shift;
    logic [9:0]  fdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rstn, input logic [3:0] valid, input logic [3:0] last,
                             input logic [31:0] data, input logic full, input logic gv,
                             input logic [1:0] gid, input logic [3:0] ready, input logic shift,
                             input logic [9:0] fdata);
    vec_t r;
    r.rstn = rstn; r.valid = valid; r.last = last; r.data = data; r.full = full;
    r.gv = gv; r.gid = gid; r.ready = ready; r.shift = shift; r.fdata = fdata;
    return r;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", name, row, got, want);
    end
  endtask

  // Inputs are driven after the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input vec_t r, input int row);
    @(negedge clk);
    resetn    = r.rstn;
    req_valid = r.valid;
    req_last  = r.last;
    req_data  = r.data;
    fifo_full = r.full;
    #1;
    check("grant_valid", row, 32'(grant_valid), 32'(r.gv));
    check("grant_id", row, 32'(grant_id), 32'(r.gid));
    check("req_ready", row, 32'(req_ready), 32'(r.ready));
    check("fifo_shift", row, 32'(fifo_shift), 32'(r.shift));
    if (r.shift) check("fifo_data", row, 32'(fifo_data), 32'(r.fdata));
  endtask

  initial begin
    resetn = 1'b0; req_valid = 4'b0001; req_last = '0; req_data = '0; fifo_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset grant_valid", 0, 32'(grant_valid), 32'd0);
    check("reset grant_id", 0, 32'(grant_id), 32'd0);
    check("reset req_ready", 0, 32'(req_ready), 32'd0);
    check("reset fifo_shift", 0, 32'(fifo_shift), 32'd0);

    // Single requester: ch2 sends A0, A1, A2(last)
    tbl.push_back(v(1, 4'b0100, 4'b0000, 32'h00A00000, 0, 0, 2'd0, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b0100, 4'b0000, 32'h00A00000, 0, 1, 2'd2, 4'b0100, 1, 10'h2A0));
    tbl.push_back(v(1, 4'b0100, 4'b0000, 32'h00A10000, 0, 1, 2'd2, 4'b0100, 1, 10'h2A1));
    tbl.push_back(v(1, 4'b0100, 4'b0100, 32'h00A20000, 0, 1, 2'd2, 4'b0100, 1, 10'h2A2));
    tbl.push_back(v(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 2'd2, 4'b0000, 0, 10'h000));
    // Reset restores pointer, then round robin over 1-word packets: 0,1,2,3,0
    tbl.push_back(v(0, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 0, 2'd2, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 0, 2'd0, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 1, 2'd0, 4'b0001, 1, 10'h0B0));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 0, 2'd0, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 1, 2'd1, 4'b0010, 1, 10'h1B1));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 0, 2'd1, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 1, 2'd2, 4'b0100, 1, 10'h2B2));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 0, 2'd2, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 1, 2'd3, 4'b1000, 1, 10'h3B3));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 0, 2'd3, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 32'hB3B2B1B0, 0, 1, 2'd0, 4'b0001, 1, 10'h0B0));
    tbl.push_back(v(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 2'd0, 4'b0000, 0, 10'h000));
    // MAXBURST cut: ch1 streams without last, ch3 waits with 1-word packets
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C000, 0, 0, 2'd0, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C000, 0, 1, 2'd1, 4'b0010, 1, 10'h1C0));
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C100, 0, 1, 2'd1, 4'b0010, 1, 10'h1C1));
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C200, 0, 1, 2'd1, 4'b0010, 1, 10'h1C2));
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C300, 0, 1, 2'd1, 4'b0010, 1, 10'h1C3));
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C400, 0, 0, 2'd1, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C400, 0, 1, 2'd3, 4'b1000, 1, 10'h3D0));
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C400, 0, 0, 2'd3, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C400, 0, 1, 2'd1, 4'b0010, 1, 10'h1C4));
    tbl.push_back(v(1, 4'b1010, 4'b1000, 32'hD000C500, 0, 1, 2'd1, 4'b0010, 1, 10'h1C5));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 32'h00000000, 0, 1, 2'd1, 4'b0000, 0, 10'h000));
    // Backpressure: full during burst cycles 2-5, and again on the last word
    tbl.push_back(v(1, 4'b0001, 4'b0000, 32'h000000E0, 0, 0, 2'd0, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b0001, 4'b0000, 32'h000000E0, 0, 1, 2'd0, 4'b0001, 1, 10'h0E0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(1, 4'b0001, 4'b0000, 32'h000000E1, 1, 1, 2'd0, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b0001, 4'b0000, 32'h000000E1, 0, 1, 2'd0, 4'b0001, 1, 10'h0E1));
    tbl.push_back(v(1, 4'b0001, 4'b0000, 32'h000000E2, 0, 1, 2'd0, 4'b0001, 1, 10'h0E2));
    tbl.push_back(v(1, 4'b0001, 4'b0001, 32'h000000E3, 1, 1, 2'd0, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b0001, 4'b0001, 32'h000000E3, 0, 1, 2'd0, 4'b0001, 1, 10'h0E3));
    tbl.push_back(v(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 2'd0, 4'b0000, 0, 10'h000));
    // Valid gap: ch2 drops valid for 3 cycles while others request
    tbl.push_back(v(1, 4'b1100, 4'b1000, 32'hD0F00000, 0, 0, 2'd0, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1100, 4'b1000, 32'hD0F00000, 0, 1, 2'd2, 4'b0100, 1, 10'h2F0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1, 4'b1011, 4'b1000, 32'hD0000000, 0, 1, 2'd2, 4'b0100, 0, 10'h000));
    tbl.push_back(v(1, 4'b1100, 4'b1100, 32'hD0F10000, 0, 1, 2'd2, 4'b0100, 1, 10'h2F1));
    tbl.push_back(v(1, 4'b1000, 4'b1000, 32'hD0000000, 0, 0, 2'd2, 4'b0000, 0, 10'h000));
    tbl.push_back(v(1, 4'b1000, 4'b1000, 32'hD0000000, 0, 1, 2'd3, 4'b1000, 1, 10'h3D0));
    tbl.push_back(v(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 2'd3, 4'b0000, 0, 10'h000));

    foreach (tbl[i]) step(tbl[i], i + 1);

    // Reset after word 2 of a 5-word ch0 packet; ch0 then wins over ch2
    step(v(1, 4'b0001, 4'b0000, 32'h00000050, 0, 0, 2'd3, 4'b0000, 0, 10'h000), 100);
    step(v(1, 4'b0001, 4'b0000, 32'h00000050, 0, 1, 2'd0, 4'b0001, 1, 10'h050), 101);
    step(v(1, 4'b0001, 4'b0000, 32'h00000051, 0, 1, 2'd0, 4'b0001, 1, 10'h051), 102);
    step(v(0, 4'b0001, 4'b0000, 32'h00000052, 0, 1, 2'd0, 4'b0000, 0, 10'h000), 103);
    step(v(1, 4'b0101, 4'b0000, 32'h00700053, 0, 0, 2'd0, 4'b0000, 0, 10'h000), 104);
    step(v(1, 4'b0101, 4'b0000, 32'h00700053, 0, 1, 2'd0, 4'b0001, 1, 10'h053), 105);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
